// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer slice.
//   op_e    : shift/rotate operation selected per request
//   state_e : sequencer FSM states
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter_step.sv
// shifter_step: one combinational step of the shift datapath.
//   data     : word to shift
//   op       : SLL / SRL / SRA / ROL
//   sel_full : 1 -> shift by SHIFTVAL, 0 -> shift by 1
//   result   : shifted word
module shifter_step
  import shift_sequencer_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int SHIFTVAL = 2
) (
  input  logic [SIZE-1:0] data,
  input  op_e             op,
  input  logic            sel_full,
  output logic [SIZE-1:0] result
);

  // cand[0] is the 1-bit step, cand[1] the SHIFTVAL-bit step. Both amounts are
  // constants, so each candidate is pure wiring plus a 4:1 mux.
  logic [1:0][SIZE-1:0] cand;

  for (genvar g = 0; g < 2; g++) begin : g_step
    localparam int N = (g == 0) ? 1 : SHIFTVAL;
    assign cand[g] =
      (op == OP_SLL) ? {data[SIZE-1-N:0], {N{1'b0}}}             :
      (op == OP_SRL) ? {{N{1'b0}}, data[SIZE-1:N]}               :
      (op == OP_SRA) ? {{N{data[SIZE-1]}}, data[SIZE-1:N]}       :
                       {data[SIZE-1-N:0], data[SIZE-1:SIZE-N]};
  end

  assign result = sel_full ? cand[1] : cand[0];

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a fixed-step shifter over several cycles to perform
// arbitrary-amount shifts/rotates. Each SHIFT cycle moves SHIFTVAL bits, or
// 1 bit once fewer than SHIFTVAL remain.
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : request handshake (accepted only in IDLE)
//   in_data/in_amt/in_op  : operand, shift amount, operation
//   abort                 : cancel an in-flight operation (ignored in IDLE)
//   out_valid/out_ready   : response handshake (valid in DONE)
//   out_data              : result, held until the next accept
//   busy                  : state != IDLE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int  SIZE     = 32,
  parameter int  SHIFTVAL = 2,
  localparam int AMTW     = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  input  logic [AMTW-1:0] in_amt,
  input  logic [1:0]      in_op,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic            busy
);

  localparam logic [AMTW-1:0] STEP_FULL = AMTW'(SHIFTVAL);

  state_e          state, state_d;
  op_e             op_q;
  logic [SIZE-1:0] data_q, step_out;
  logic [AMTW-1:0] rem, rem_nxt, step_amt;
  logic            sel_full, accept;

  assign sel_full = (rem >= STEP_FULL);
  assign step_amt = sel_full ? STEP_FULL : AMTW'(1);
  assign rem_nxt  = rem - step_amt;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = data_q;

  shifter_step #(.SIZE(SIZE), .SHIFTVAL(SHIFTVAL)) u_step (
    .data     (data_q),
    .op       (op_q),
    .sel_full (sel_full),
    .result   (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (in_valid) state_d = (in_amt == '0) ? DONE : SHIFT;
      SHIFT: if (abort)                 state_d = IDLE;
             else if (rem_nxt == '0)    state_d = DONE;
      DONE:  if (abort || out_ready)    state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Datapath only changes on accept or a live SHIFT step, so out_data holds
  // its last value through DONE, backpressure and the following IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      rem    <= '0;
      op_q   <= OP_SLL;
    end else if (accept) begin
      data_q <= in_data;
      rem    <= in_amt;
      op_q   <= op_e'(in_op);
    end else if (busy && abort) begin
      rem    <= '0;
    end else if (state == SHIFT) begin
      data_q <= step_out;
      rem    <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  localparam int SIZE = 32;
  localparam int SV   = 2;

  logic            clk = 0, rst = 1;
  logic            in_valid = 0, in_ready, abort = 0, out_valid, out_ready = 0, busy;
  logic [SIZE-1:0] in_data = '0, out_data;
  logic [4:0]      in_amt = '0;
  logic [1:0]      in_op = '0;

  int checks = 0, failures = 0;

  shift_sequencer #(.SIZE(SIZE), .SHIFTVAL(SV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Composition of per-step shifts equals one shift by the full amount.
  function automatic logic [31:0] model(input logic [31:0] d, input int a, input logic [1:0] op);
    case (op)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return 32'($signed(d) >>> a);
      default: return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
    endcase
  endfunction

  function automatic int model_lat(input int a);
    return a / SV + a % SV + 1;
  endfunction

  // Issue one request, count edges until out_valid, hold backpressure for bp
  // cycles, then consume the result.
  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                        input int bp, output logic [31:0] res, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_data = d; in_amt = a; in_op = op;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 0;
      lat++;
    end while (!out_valid && lat < 200);
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    res = out_data;
    // Competing request during backpressure must not be taken.
    in_valid = 1; in_data = ~d; in_amt = 5'd1; in_op = 2'd0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, res);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    chk("rel_hold_data", out_data, res);
  endtask

  initial begin
    logic [31:0] res, exp;
    int lat, a, bp;
    logic [31:0] d;
    logic [1:0] op;

    vecs[0] = '{32'h00000001,  5, 2'd0, 32'h00000020, 4};
    vecs[1] = '{32'h80000000,  4, 2'd2, 32'hF8000000, 3};
    vecs[2] = '{32'h80000000,  4, 2'd1, 32'h08000000, 3};
    vecs[3] = '{32'h80000001,  3, 2'd3, 32'h0000000C, 3};
    vecs[4] = '{32'hDEADBEEF,  0, 2'd2, 32'hDEADBEEF, 1};
    vecs[5] = '{32'h00000001, 31, 2'd0, 32'h80000000, 17};
    vecs[6] = '{32'h12345678, 16, 2'd3, 32'h56781234, 9};
    vecs[7] = '{32'h7FFFFFFF, 31, 2'd2, 32'h00000000, 17};

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].amt, vecs[i].op, (i == 0) ? 5 : 0, res, lat);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Abort in the 2nd SHIFT cycle of an amt=31 SLL
    @(negedge clk);
    in_valid = 1; in_data = 32'h1; in_amt = 5'd31; in_op = 2'd0;
    @(posedge clk); #1; in_valid = 0;
    chk("abort_busy", busy, 1);
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy_low", busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) chk("abort_no_valid", out_valid, 0);
    end
    run_op(32'h1, 5'd1, 2'd0, 0, res, lat);
    chk("post_abort_data", res, 32'h2);
    chk("post_abort_lat", lat, 2);

    // Abort in IDLE with a request present: still accepted
    @(negedge clk);
    abort = 1; in_valid = 1; in_data = 32'h3; in_amt = 5'd2; in_op = 2'd0;
    @(posedge clk); #1; abort = 0; in_valid = 0;
    chk("idle_abort_accept", busy, 1);
    @(posedge clk); #1;
    chk("idle_abort_done", out_valid, 1);
    chk("idle_abort_data", out_data, 32'hC);
    // abort beats out_ready in DONE
    abort = 1; out_ready = 1;
    @(posedge clk); #1; abort = 0; out_ready = 0;
    chk("abort_done_idle", in_ready, 1);

    // Async reset mid-SHIFT
    @(negedge clk);
    in_valid = 1; in_data = 32'hA5A5A5A5; in_amt = 5'd31; in_op = 2'd3;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1; #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); rst = 0;
    run_op(32'h0F0F0F0F, 5'd4, 2'd1, 0, res, lat);
    chk("post_rst_data", res, 32'h00F0F0F0);

    // Randomized vs. model
    for (int n = 0; n < 40; n++) begin
      d  = $urandom;
      a  = $urandom_range(0, 31);
      op = 2'($urandom_range(0, 3));
      bp = $urandom_range(0, 3);
      run_op(d, 5'(a), op, bp, res, lat);
      exp = model(d, a, op);
      chk($sformatf("rnd%0d_data", n), res, exp);
      chk($sformatf("rnd%0d_lat", n), lat, model_lat(a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that sequences a fixed-step shifter datapath to perform arbitrary-amount shifts and rotates on a SIZE-bit word. Each cycle it applies one step of SHIFTVAL bits, or 1 bit when fewer than SHIFTVAL bits remain. The caller side uses a valid/ready request handshake and the result side uses a valid/ready response handshake. It sits between an ALU-style issuer and the shifter datapath, so one narrow shifter can serve any shift amount.

Parameters:
SIZE, 32, data word width in bits (>= 2)
SHIFTVAL, 2, coarse step in bits per cycle (1 <= SHIFTVAL < SIZE)
AMTW, $clog2(SIZE), shift-amount width (derived localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready at clk edge
in_data  in  SIZE  operand
in_amt  in  AMTW  shift amount, 0..SIZE-1
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
abort  in  1  synchronous cancel of in-flight operation
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready at clk edge
out_data  out  SIZE  result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, internal remainder=0, op=0.
- States:
  - IDLE: in_ready=1. On accept, latch data/amt/op. Go to DONE if amt==0, else to SHIFT.
  - SHIFT: each edge computes step = (rem >= SHIFTVAL) ? SHIFTVAL : 1, then data <= shift(data, step, op) and rem <= rem - step. Go to DONE when the new rem == 0.
  - DONE: out_valid=1, out_data holds the result. On out_ready, go to IDLE. out_data keeps its value until the next accept.
- in_ready is combinationally (state==IDLE). No request is accepted in SHIFT or DONE, so there is no same-cycle handshake through DONE->IDLE.
- Latency: number of SHIFT cycles N = amt/SHIFTVAL + amt%SHIFTVAL. out_valid rises N+1 edges after the accept edge (N=0 for amt 0, giving 1 edge).
- Op semantics per step:
  - SLL: zero fill at LSB.
  - SRL: zero fill at MSB.
  - SRA: replicate MSB.
  - ROL: bits leaving the MSB re-enter at the LSB.
- abort:
  - In SHIFT or DONE: next state IDLE, out_valid=0, rem=0, result discarded.
  - In IDLE: ignored. If in_valid is also high, the request is still accepted.
  - abort has priority over out_ready.
- out_valid stays high while out_ready is low. out_data is stable during backpressure.
- rst asserted mid-operation returns to the reset state immediately. No partial result is visible after reset.
- in_amt is interpreted unsigned. Values are bounded to SIZE-1 by width, so no out-of-range handling exists.

Decomposition:
- Shared package/include holds op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11) and state encodings (IDLE, SHIFT, DONE).
- One combinational sub-module, shifter_step (SIZE, SHIFTVAL), takes data, op, and a sel_full flag (step SHIFTVAL vs 1) and returns the shifted word. It is the datapath that the sequencer drives.
- The sequencer itself holds the FSM, remainder counter, and handshake logic.

Test Plan:
- SLL, in_data=0x00000001, amt=5 (SIZE=32, SHIFTVAL=2) -> steps 2,2,1. out_valid 4 edges after accept; out_data=0x00000020.
- SRA, in_data=0x80000000, amt=4 -> 2 SHIFT cycles; out_data=0xF8000000. Then SRL with the same inputs -> 0x08000000.
- ROL, in_data=0x80000001, amt=3 -> out_data=0x0000000C. amt=0 with any op -> out_valid 1 edge after accept, out_data == in_data.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout, no new request accepted. Release -> IDLE next edge, in_ready=1.
- abort at the 2nd SHIFT cycle of an amt=31 SLL -> IDLE next edge, out_valid never asserted. A following request (0x1, amt=1, SLL) returns 0x2.
- rst pulsed mid-SHIFT (asynchronous, between edges) -> outputs immediately at reset values (in_ready=1, out_valid=0, out_data=0, busy=0). Normal operation resumes after rst deasserts.
